// File: rtl/mdr_unit.sv
// Memory data register for the LC-3 datapath: selectable bus/memory load source,
// wait-state read sequencer with a one-cycle ready strobe, and a tri-state bus driver.
module mdr_unit #(
  parameter int WIDTH    = 16,
  parameter int MEM_WAIT = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MDR,
  input  logic             MIO_EN,
  input  logic             GateMDR,
  input  logic             MEM_RD_REQ,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [WIDTH-1:0] mem_data_in,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] mem_data_out,
  output logic             mem_oe,
  output logic             R,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int CW = 4;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [WIDTH-1:0] mdr;

  // Handshake: MEM_RD_REQ is accepted only in IDLE (no queuing); R is a
  // single-cycle ready strobe in READY, the only cycle memory data may load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_oe    = 1'b0;
    R         = 1'b0;
    case (state)
      IDLE: begin
        if (MEM_RD_REQ) begin
          state_nxt = BUSY;
          cnt_nxt   = CW'(MEM_WAIT - 1);
        end
      end
      BUSY: begin
        mem_oe = 1'b1;
        if (cnt == '0) state_nxt = READY;
        else           cnt_nxt   = cnt - 1'b1;
      end
      READY: begin
        mem_oe    = 1'b1;
        R         = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A memory-sourced load outside READY is dropped; the register never clears on idle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mdr <= '0;
    end else if (LD_MDR) begin
      if (!MIO_EN)              mdr <= bus_in;
      else if (state == READY)  mdr <= mem_data_in;
    end
  end

  assign mem_data_out = mdr;
  assign bus_out      = GateMDR ? mdr : {WIDTH{1'bz}};
  assign fsm_state    = state;

endmodule

// File: doc/mdr_unit.md
Name: mdr_unit

Overview:
Parametrised memory data register for the LC-3 datapath, successor to the single-source MDR.
- Selects its load source: CPU bus or memory read data (MIO_EN).
- Sequences memory reads with a programmable wait-state counter and a one-cycle ready strobe (R) for the control FSM.
- Drives the shared CPU bus through a tri-state gate (GateMDR).
- Sits between the bus, the memory/IO interface and the control unit.

Parameters:
WIDTH, 16, data width of the register, bus and memory ports
MEM_WAIT, 2, memory read wait cycles before data is valid (legal range 1..15)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
LD_MDR  input  1  load enable for the register
MIO_EN  input  1  load source select: 1 = mem_data_in, 0 = bus_in
GateMDR  input  1  drive register contents onto bus_out
MEM_RD_REQ  input  1  start a memory read sequence (sampled in IDLE only)
bus_in  input  WIDTH  value from the CPU bus
mem_data_in  input  WIDTH  read data from memory
bus_out  output  WIDTH  register value when GateMDR=1, all Z otherwise
mem_data_out  output  WIDTH  register value to memory, always driven
mem_oe  output  1  memory output enable during a read sequence
R  output  1  read data ready strobe, one cycle

Behaviour:
- Reset is synchronous and active-high, sampled only on the Clk rising edge. When Reset=1 at an edge:
  - the register is cleared to 0
  - the FSM goes to IDLE and the wait counter is cleared
  - R=0 and mem_oe=0
  - bus_out=Z unless GateMDR=1, in which case it shows 0
- Reset has priority over all other inputs, including mid-sequence. A read in progress is abandoned and no load occurs.
- FSM states:
  - IDLE: mem_oe=0, R=0. On MEM_RD_REQ=1, go to BUSY and load the counter with MEM_WAIT-1.
  - BUSY: mem_oe=1, R=0. The counter decrements each cycle. When the counter is 0, go to READY.
  - READY: mem_oe=1, R=1 for exactly this cycle. Next state is always IDLE.
- Read latency: a request sampled at edge t gives R=1 in the cycle after edge t+MEM_WAIT, i.e. MEM_WAIT+1 cycles after the request cycle.
- MEM_RD_REQ while in BUSY or READY is ignored. No queuing.
- Register load rules, applied at the rising edge:
  - LD_MDR=1 and MIO_EN=0: register <= bus_in, in any FSM state.
  - LD_MDR=1 and MIO_EN=1: register <= mem_data_in, only if the FSM is in READY. In any other state the load is dropped and the register holds.
  - LD_MDR=0: register holds.
  - The old MDR cleared to Z when not loading. This block always holds its value when not loading.
- Output timing:
  - bus_out and mem_data_out are combinational from the register (and GateMDR), so a load is visible the cycle after the edge.
  - GateMDR has no effect on state. With simultaneous GateMDR and LD_MDR, bus_out shows the pre-load value until the edge.
  - mem_oe and R are decoded from the state with no combinational path from inputs.
- Width: all data paths are WIDTH bits, with no extension or truncation.

Test Plan:
1. Reset=1 for 2 cycles with GateMDR=0, then GateMDR=1 -> bus_out=Z then 16'h0000; R=0, mem_oe=0.
2. bus_in=16'h1234, LD_MDR=1, MIO_EN=0 for one edge -> mem_data_out=16'h1234 next cycle; GateMDR=1 gives bus_out=16'h1234.
3. MEM_RD_REQ pulse at cycle 0, MEM_WAIT=2, mem_data_in=16'hBEEF, LD_MDR=1, MIO_EN=1 held -> mem_oe=1 in cycles 1-3; R=1 only in cycle 3; register=16'hBEEF from cycle 4; no load in cycles 1-2.
4. LD_MDR=1, MIO_EN=1 in IDLE with no read, mem_data_in=16'hFFFF, register=16'h1234 -> register stays 16'h1234.
5. Reset=1 in cycle 2 of the read from scenario 3 -> cycle 3 has state IDLE, R=0, mem_oe=0, register=0. A MEM_RD_REQ issued during BUSY is also ignored, producing exactly one R pulse.
6. Rerun scenario 3 with MEM_WAIT=1 and WIDTH=8 -> R=1 in cycle 2; 8-bit data loads correctly.
